// File: rtl/custom_ip_reg_pkg.sv
// ---------------------------------------------------------------------------
// custom_ip_reg_pkg
// Shared address map constants, the APB slave state type and an address
// helper for the custom IP register bank.
// ---------------------------------------------------------------------------
package custom_ip_reg_pkg;

  localparam logic [7:0] CTRL_BASE = 8'h00;
  localparam logic [7:0] STAT_BASE = 8'h40;
  localparam logic [7:0] UPD_OFS   = 8'h80;
  localparam logic [7:0] OVF_OFS   = 8'h84;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } apb_state_e;

  // Byte address of word 'idx' inside a register array starting at 'base'.
  function automatic logic [7:0] reg_addr(input logic [7:0] base, input int unsigned idx);
    return base + 8'(idx * 32'd4);
  endfunction

endpackage

// File: rtl/custom_ip_status_slice.sv
// ---------------------------------------------------------------------------
// custom_ip_status_slice
// One status register with its sticky update/overflow flags. The IP capture
// strobe always wins over a same-cycle software W1C of the same flag.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   cap_i           capture strobe from the IP
//   cap_data_i      status data captured on cap_i
//   upd_clr_i       W1C clear request for the update flag
//   ovf_clr_i       W1C clear request for the overflow flag
//   stat_o          captured status value
//   upd_o, ovf_o    sticky update / overflow flags
// ---------------------------------------------------------------------------
module custom_ip_status_slice #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cap_i,
  input  logic [DW-1:0] cap_data_i,
  input  logic          upd_clr_i,
  input  logic          ovf_clr_i,
  output logic [DW-1:0] stat_o,
  output logic          upd_o,
  output logic          ovf_o
);

  logic [DW-1:0] stat_q, stat_d;
  logic          upd_q, upd_d;
  logic          ovf_q, ovf_d;

  // Next-state: capture, flag set and W1C arbitration.
  always_comb begin
    stat_d = stat_q;
    upd_d  = upd_q;
    ovf_d  = ovf_q;
    if (cap_i) begin
      stat_d = cap_data_i;
      upd_d  = 1'b1;
    end else if (upd_clr_i) begin
      upd_d = 1'b0;
    end else begin
      upd_d = upd_q;
    end
    // Overflow means a capture landed while the previous one was still unseen;
    // it looks at the flag value before any clear of this cycle.
    if (cap_i && upd_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Status and flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_q <= {DW{1'b0}};
      upd_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      upd_q  <= upd_d;
      ovf_q  <= ovf_d;
    end
  end

  assign stat_o = stat_q;
  assign upd_o  = upd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/custom_ip_regbank.sv
// ---------------------------------------------------------------------------
// custom_ip_regbank
// APB3 slave register bank between software and a custom IP. CTRL registers
// drive the IP together with a one-cycle write pulse; STAT registers and
// sticky UPD/OVF flags are filled by the IP. Every transfer has one wait
// state (IDLE -> ACCESS -> RESP).
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   psel_i, penable_i, pwrite_i  APB control
//   paddr_i, pwdata_i            APB byte address / write data
//   prdata_o, pready_o, pslverr_o APB response (registered)
//   reg2ip_data_o, reg2ip_en_o   CTRL contents and per-register write pulse
//   ip2reg_data_i, ip2reg_en_i   IP status data and capture strobes
// ---------------------------------------------------------------------------
module custom_ip_regbank
  import custom_ip_reg_pkg::*;
#(
  parameter int NUM_REGS = 3,
  parameter int DW       = 32,
  parameter int AW       = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AW-1:0]          paddr_i,
  input  logic [DW-1:0]          pwdata_i,
  output logic [DW-1:0]          prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic [NUM_REGS*DW-1:0] reg2ip_data_o,
  output logic [NUM_REGS-1:0]    reg2ip_en_o,
  input  logic [NUM_REGS*DW-1:0] ip2reg_data_i,
  input  logic [NUM_REGS-1:0]    ip2reg_en_i
);

  apb_state_e            state_q, state_d;
  logic [DW-1:0]         ctrl_q [NUM_REGS];
  logic [DW-1:0]         ctrl_d [NUM_REGS];
  logic [DW-1:0]         prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0]   reg2ip_en_q, reg2ip_en_d;

  logic [NUM_REGS-1:0]   ctrl_sel_s, stat_sel_s;
  logic                  upd_sel_s, ovf_sel_s, dec_err_s;
  logic [DW-1:0]         rdata_s;
  logic [NUM_REGS-1:0]   upd_clr_s, ovf_clr_s;
  logic [DW-1:0]         stat_s [NUM_REGS];
  logic [NUM_REGS-1:0]   upd_s, ovf_s;
  logic [NUM_REGS*DW-1:0] reg2ip_data_s;

  // Status slices, one per register pair.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_stat
    custom_ip_status_slice #(.DW(DW)) u_slice (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cap_i      (ip2reg_en_i[g]),
      .cap_data_i (ip2reg_data_i[g*DW +: DW]),
      .upd_clr_i  (upd_clr_s[g]),
      .ovf_clr_i  (ovf_clr_s[g]),
      .stat_o     (stat_s[g]),
      .upd_o      (upd_s[g]),
      .ovf_o      (ovf_s[g])
    );
  end

  // Address decode and read mux. Exact-match compares against word-aligned
  // addresses make unaligned and out-of-range accesses fall out as misses.
  always_comb begin
    rdata_s = {DW{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      ctrl_sel_s[i] = (paddr_i == AW'(reg_addr(CTRL_BASE, i)));
      stat_sel_s[i] = (paddr_i == AW'(reg_addr(STAT_BASE, i)));
      rdata_s = rdata_s
              | (ctrl_sel_s[i] ? ctrl_q[i] : {DW{1'b0}})
              | (stat_sel_s[i] ? stat_s[i] : {DW{1'b0}});
    end
    upd_sel_s = (paddr_i == AW'(UPD_OFS));
    ovf_sel_s = (paddr_i == AW'(OVF_OFS));
    rdata_s = rdata_s
            | (upd_sel_s ? DW'(upd_s) : {DW{1'b0}})
            | (ovf_sel_s ? DW'(ovf_s) : {DW{1'b0}});
    dec_err_s = !((|ctrl_sel_s) || (|stat_sel_s) || upd_sel_s || ovf_sel_s)
              || (pwrite_i && (|stat_sel_s));
  end

  // APB FSM next state, side effects and response.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    prdata_d    = {DW{1'b0}};
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    reg2ip_en_d = {NUM_REGS{1'b0}};
    upd_clr_s   = {NUM_REGS{1'b0}};
    ovf_clr_s   = {NUM_REGS{1'b0}};
    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          state_d  = RESP;
          pready_d = 1'b1;
          if (dec_err_s) begin
            pslverr_d = 1'b1;
          end else if (pwrite_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (ctrl_sel_s[i]) begin
                ctrl_d[i]      = pwdata_i;
                reg2ip_en_d[i] = 1'b1;
              end else begin
                ctrl_d[i] = ctrl_q[i];
              end
            end
            upd_clr_s = upd_sel_s ? pwdata_i[NUM_REGS-1:0] : {NUM_REGS{1'b0}};
            ovf_clr_s = ovf_sel_s ? pwdata_i[NUM_REGS-1:0] : {NUM_REGS{1'b0}};
          end else begin
            prdata_d = rdata_s;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, control and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ctrl_q      <= '{default: {DW{1'b0}}};
      prdata_q    <= {DW{1'b0}};
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      reg2ip_en_q <= {NUM_REGS{1'b0}};
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      reg2ip_en_q <= reg2ip_en_d;
    end
  end

  // Flatten CTRL registers onto the IP-facing bus.
  always_comb begin
    reg2ip_data_s = {(NUM_REGS*DW){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      reg2ip_data_s[i*DW +: DW] = ctrl_q[i];
    end
  end

  assign reg2ip_data_o = reg2ip_data_s;
  assign reg2ip_en_o   = reg2ip_en_q;
  assign prdata_o      = prdata_q;
  assign pready_o      = pready_q;
  assign pslverr_o     = pslverr_q;

endmodule
